sd_cmd_tx: RTL

//  Host-side SD command transmitter; sits directly upstream of the response receive stage.

---
 rtl/sd_pkg.sv | 28 ++
 rtl/sd_cmd_tx_if.sv | 23 ++
 rtl/sd_crc7_serial.sv | 36 +++
 rtl/sd_cmd_tx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD command path: response codes, frame sizes,
// transmitter state encoding and the serial CRC7 step.
package sd_pkg;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_48   = 2'd1;
    localparam logic [1:0] RESP_136  = 2'd2;

    localparam logic [6:0] CRC7_POLY      = 7'h09;
    localparam int         CMD_FRAME_BITS = 48;
    localparam int         CMD_HDR_BITS   = 40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_HDR,
        ST_SEND_CRC,
        ST_SEND_END,
        ST_GAP,
        ST_DONE
    } cmd_state_e;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_cmd_tx_if.sv
// Request/status bundle between the host controller (master) and the
// SD command transmitter (slave).
interface sd_cmd_tx_if;
    logic        start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [1:0]  resp_type;
    logic        busy;
    logic        done;
    logic        receive_en;
    logic        R2_response;
    logic [6:0]  crc_out;

    modport master (
        output start, cmd_index, cmd_arg, resp_type,
        input  busy, done, receive_en, R2_response, crc_out
    );

    modport slave (
        input  start, cmd_index, cmd_arg, resp_type,
        output busy, done, receive_en, R2_response, crc_out
    );
endinterface

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), one bit per enabled clock; shared by the
// command transmit and response receive paths.
module sd_crc7_serial
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 7'h00;
        end else if (en) begin
            crc_d = crc7_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_tx.sv
// Host-side SD command transmitter: serialises start/transmit/index/arg/CRC7/end
// onto CMD. Optional Ncc release gap before done under `SD_CMD_TX_NCC_EN.
module sd_cmd_tx
    import sd_pkg::*;
`ifdef SD_CMD_TX_NCC_EN
#(
    parameter int NCC_CYCLES = 8
)
`endif
(
    input  logic          sd_clk,
    input  logic          reset,
    sd_cmd_tx_if.slave    cmd_if,
    output logic          sd_cmd_out,
    output logic          sd_cmd_oe
);

    cmd_state_e  state_q;
    logic [39:0] shreg_q;
    logic [5:0]  cnt_q;
    logic        resp_en_q;
    logic        r2_q;
    logic        busy_q;
    logic        done_q;
    logic        rcv_q;
    logic        out_q;
    logic        oe_q;
    logic [6:0]  crc_out_q;

`ifdef SD_CMD_TX_NCC_EN
    localparam int GAP_W = $clog2(NCC_CYCLES + 1);
    logic [GAP_W-1:0] gap_q;
`endif

    logic       crc_clear;
    logic       crc_en;
    logic       crc_bit;
    logic [6:0] crc;

    // During SEND_CRC the register is fed its own MSB, which zeroes the
    // feedback term and turns the CRC into a plain MSB-first shifter.
    assign crc_clear = (state_q == ST_IDLE) && cmd_if.start;
    assign crc_en    = (state_q == ST_SEND_HDR) || (state_q == ST_SEND_CRC);
    assign crc_bit   = (state_q == ST_SEND_HDR) ? shreg_q[39] : crc[6];

    sd_crc7_serial u_crc (
        .clk    (sd_clk),
        .reset  (reset),
        .clear  (crc_clear),
        .en     (crc_en),
        .bit_in (crc_bit),
        .crc    (crc)
    );

    always_ff @(posedge sd_clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= 40'd0;
            cnt_q     <= 6'd0;
            resp_en_q <= 1'b0;
            r2_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rcv_q     <= 1'b0;
            out_q     <= 1'b1;
            oe_q      <= 1'b0;
            crc_out_q <= 7'h00;
`ifdef SD_CMD_TX_NCC_EN
            gap_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            rcv_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    out_q  <= 1'b1;
                    oe_q   <= 1'b0;
                    busy_q <= 1'b0;
                    if (cmd_if.start) begin
                        shreg_q   <= {2'b01, cmd_if.cmd_index, cmd_if.cmd_arg};
                        resp_en_q <= (cmd_if.resp_type != RESP_NONE);
                        r2_q      <= (cmd_if.resp_type == RESP_136);
                        busy_q    <= 1'b1;
                        cnt_q     <= 6'd0;
                        state_q   <= ST_SEND_HDR;
                    end
                end
                ST_SEND_HDR: begin
                    out_q   <= shreg_q[39];
                    oe_q    <= 1'b1;
                    shreg_q <= {shreg_q[38:0], 1'b0};
                    cnt_q   <= cnt_q + 6'd1;
                    if (cnt_q == 6'(CMD_HDR_BITS - 1)) begin
                        state_q <= ST_SEND_CRC;
                    end
                end
                ST_SEND_CRC: begin
                    out_q <= crc[6];
                    oe_q  <= 1'b1;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(CMD_HDR_BITS)) begin
                        crc_out_q <= crc;
                    end
                    if (cnt_q == 6'(CMD_FRAME_BITS - 2)) begin
                        state_q <= ST_SEND_END;
                    end
                end
                ST_SEND_END: begin
                    out_q <= 1'b1;
                    oe_q  <= 1'b1;
                    cnt_q <= cnt_q + 6'd1;
`ifdef SD_CMD_TX_NCC_EN
                    gap_q   <= '0;
                    state_q <= ST_GAP;
`else
                    state_q <= ST_DONE;
`endif
                end
`ifdef SD_CMD_TX_NCC_EN
                ST_GAP: begin
                    out_q <= 1'b1;
                    oe_q  <= 1'b0;
                    gap_q <= gap_q + 1'b1;
                    if (gap_q == GAP_W'(NCC_CYCLES - 1)) begin
                        state_q <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    done_q  <= 1'b1;
                    rcv_q   <= resp_en_q;
                    out_q   <= 1'b1;
                    oe_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    out_q   <= 1'b1;
                    oe_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sd_cmd_out         = out_q;
    assign sd_cmd_oe          = oe_q;
    assign cmd_if.busy        = busy_q;
    assign cmd_if.done        = done_q;
    assign cmd_if.receive_en  = rcv_q;
    assign cmd_if.R2_response = r2_q;
    assign cmd_if.crc_out     = crc_out_q;

endmodule
